// File: rtl/vram_pkg.sv
// vram_pkg: shared definitions for the dual-port video RAM.
//   - fill_state_t : fill engine FSM states (IDLE, FILL, DONE)
//   - DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word and address widths
package vram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vram_dp_if.sv
// vram_dp_if: bus bundle for the dual-port video RAM.
//   CPU port   : cpu_en, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ready
//   Video port : vid_en, vid_addr -> vid_rdata, vid_valid
//   Fill port  : fill_start, fill_value -> fill_busy, fill_done
//   master modport = requester side, slave modport = memory side.
interface vram_dp_if
  import vram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  cpu_en;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;

  logic                  vid_en;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [DATA_WIDTH-1:0] vid_rdata;
  logic                  vid_valid;

  logic                  fill_start;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  fill_busy;
  logic                  fill_done;

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output vid_en, vid_addr,
    input  vid_rdata, vid_valid,
    output fill_start, fill_value,
    input  fill_busy, fill_done
  );

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  vid_en, vid_addr,
    output vid_rdata, vid_valid,
    input  fill_start, fill_value,
    output fill_busy, fill_done
  );

endinterface

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: memory fill engine.
//   clk, rst_n        : clock, async active-low reset
//   start, value_in   : fill request pulse and fill word (latched on accept)
//   busy, done        : engine active (FILL/DONE), one-cycle completion pulse
//   we, addr, data    : write request toward the memory write mux
// Writes the latched word to addresses 0..SIZE-1, one per cycle, then
// spends one cycle in DONE before returning to IDLE.
module vram_fill_ctrl
  import vram_pkg::*;
#(
  parameter int                    DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int                    FILL_ON_RESET    = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value_in,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam fill_state_t RESET_STATE = (FILL_ON_RESET != 0) ? FILL : IDLE;

  fill_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic [DATA_WIDTH-1:0] val, val_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
      val   <= RESET_FILL_VALUE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      val   <= val_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    val_next   = val;
    busy       = 1'b0;
    done       = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          cnt_next   = '0;
          val_next   = value_in;
        end
      end
      FILL: begin
        busy = 1'b1;
        we   = 1'b1;
        // Terminal address is all-ones; counter stops there instead of wrapping.
        if (cnt == '1) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign addr = cnt;
  assign data = val;

endmodule

// File: rtl/vram_dp.sv
// vram_dp: dual-port video RAM with CPU read/write port, video read port
// and a whole-memory fill engine.
//   clk, rst_n : clock, async active-low reset
//   bus        : vram_dp_if slave (CPU, video and fill signal groups)
// CPU access is stalled (cpu_ready=0) while the fill engine is busy.
// The video port reads every cycle it is enabled and is read-first against
// the single shared write port (fill has priority over CPU).
module vram_dp
  import vram_pkg::*;
#(
  parameter int                    DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int                    FILL_ON_RESET    = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_FILL_VALUE = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  vram_dp_if.slave bus
);

  localparam int SIZE = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_busy;
  logic                  fill_done;

  logic                  cpu_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  vram_fill_ctrl #(
    .DATA_WIDTH       (DATA_WIDTH),
    .ADDR_WIDTH       (ADDR_WIDTH),
    .FILL_ON_RESET    (FILL_ON_RESET),
    .RESET_FILL_VALUE (RESET_FILL_VALUE)
  ) u_fill (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.fill_start),
    .value_in (bus.fill_value),
    .busy     (fill_busy),
    .done     (fill_done),
    .we       (fill_we),
    .addr     (fill_addr),
    .data     (fill_data)
  );

  assign bus.fill_busy = fill_busy;
  assign bus.fill_done = fill_done;
  assign bus.cpu_ready = ~fill_busy;
  assign cpu_acc       = bus.cpu_en & ~fill_busy;

  // Single write port: fill engine first, then CPU. rst_n gates the enable
  // because the fill FSM sits in FILL during reset when auto-fill is on.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (fill_we) begin
      mem_we    = 1'b1;
      mem_waddr = fill_addr;
      mem_wdata = fill_data;
    end else if (cpu_acc && bus.cpu_we) begin
      mem_we = 1'b1;
    end
    mem_we = mem_we & rst_n;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cpu_rdata <= '0;
    end else if (cpu_acc && !bus.cpu_we) begin
      bus.cpu_rdata <= mem[bus.cpu_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vid_rdata <= '0;
      bus.vid_valid <= 1'b0;
    end else begin
      bus.vid_valid <= bus.vid_en;
      if (bus.vid_en) begin
        bus.vid_rdata <= mem[bus.vid_addr];
      end
    end
  end

endmodule

// File: tb/tb_vram_dp.sv
module tb_vram_dp;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vram_dp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
  vram_dp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

  vram_dp #(
    .DATA_WIDTH       (8),
    .ADDR_WIDTH       (4),
    .FILL_ON_RESET    (1),
    .RESET_FILL_VALUE (8'h00)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ifa)
  );

  vram_dp #(
    .DATA_WIDTH       (8),
    .ADDR_WIDTH       (4),
    .FILL_ON_RESET    (0),
    .RESET_FILL_VALUE (8'h00)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    int done_idx;
    int done_cnt;

    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.cpu_en = 0; ifa.cpu_we = 0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifa.vid_en = 0; ifa.vid_addr = '0; ifa.fill_start = 0; ifa.fill_value = '0;
    ifb.cpu_en = 0; ifb.cpu_we = 0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    ifb.vid_en = 0; ifb.vid_addr = '0; ifb.fill_start = 0; ifb.fill_value = '0;

    // Reset state
    #12;
    chk("rst_cpu_rdata", ifa.cpu_rdata, 8'h00);
    chk("rst_vid_rdata", ifa.vid_rdata, 8'h00);
    chk("rst_vid_valid", ifa.vid_valid, 1'b0);
    chk("rst_fill_done", ifa.fill_done, 1'b0);
    chk("rst_a_busy", ifa.fill_busy, 1'b1);
    chk("rst_a_ready", ifa.cpu_ready, 1'b0);
    chk("rst_b_busy", ifb.fill_busy, 1'b0);
    chk("rst_b_ready", ifb.cpu_ready, 1'b1);

    // Auto-fill after reset release: 17 busy cycles, done on the 17th
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    busy_cycles = 0; done_idx = -1; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (ifa.fill_busy) busy_cycles++;
      if (ifa.fill_done) begin done_cnt++; done_idx = k; end
    end
    chk("auto_busy_cycles", busy_cycles, 17);
    chk("auto_done_idx", done_idx, 16);
    chk("auto_done_count", done_cnt, 1);
    chk("auto_ready_after", ifa.cpu_ready, 1'b1);

    for (int a = 0; a < 16; a++) begin
      ifa.cpu_en = 1; ifa.cpu_we = 0; ifa.cpu_addr = a[3:0];
      tick();
      chk($sformatf("auto_word_%0d", a), ifa.cpu_rdata, 8'h00);
    end

    // CPU write then read
    ifa.cpu_en = 1; ifa.cpu_we = 1; ifa.cpu_addr = 4'h3; ifa.cpu_wdata = 8'hA5;
    tick();
    ifa.cpu_we = 0;
    tick();
    chk("cpu_read_a5", ifa.cpu_rdata, 8'hA5);
    ifa.cpu_en = 0;
    tick();
    chk("cpu_rdata_hold", ifa.cpu_rdata, 8'hA5);

    // Same-edge CPU write and video read: read-first
    ifa.cpu_en = 1; ifa.cpu_we = 1; ifa.cpu_addr = 4'h7; ifa.cpu_wdata = 8'h5A;
    ifa.vid_en = 1; ifa.vid_addr = 4'h7;
    tick();
    chk("vid_read_first_old", ifa.vid_rdata, 8'h00);
    chk("vid_valid_on", ifa.vid_valid, 1'b1);
    ifa.cpu_en = 0; ifa.cpu_we = 0;
    tick();
    chk("vid_read_new", ifa.vid_rdata, 8'h5A);
    ifa.vid_en = 0;
    tick();
    chk("vid_valid_off", ifa.vid_valid, 1'b0);
    chk("vid_rdata_hold", ifa.vid_rdata, 8'h5A);

    // Explicit fill 0xFF with video scanning addr 3, CPU write held, second start ignored
    ifa.fill_start = 1; ifa.fill_value = 8'hFF;
    ifa.vid_en = 1; ifa.vid_addr = 4'h3;
    tick();
    ifa.fill_start = 0; ifa.fill_value = 8'h12;
    chk("fill_busy_start", ifa.fill_busy, 1'b1);
    chk("fill_ready_low", ifa.cpu_ready, 1'b0);
    chk("fill_vid_pre", ifa.vid_rdata, 8'hA5);
    ifa.cpu_en = 1; ifa.cpu_we = 1; ifa.cpu_addr = 4'h9; ifa.cpu_wdata = 8'h77;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ifa.fill_start = (k == 5);
      chk($sformatf("fill_ready_k%0d", k), ifa.cpu_ready, (k >= 17) ? 1'b1 : 1'b0);
      chk($sformatf("fill_done_k%0d", k), ifa.fill_done, (k == 16) ? 1'b1 : 1'b0);
      chk($sformatf("fill_vvalid_k%0d", k), ifa.vid_valid, 1'b1);
      chk($sformatf("fill_vdata_k%0d", k), ifa.vid_rdata, (k <= 4) ? 8'hA5 : 8'hFF);
    end
    ifa.cpu_en = 0; ifa.cpu_we = 0; ifa.fill_start = 0; ifa.vid_en = 0;
    tick();
    chk("fill_idle_after", ifa.fill_busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      ifa.cpu_en = 1; ifa.cpu_we = 0; ifa.cpu_addr = a[3:0];
      tick();
      chk($sformatf("fill_word_%0d", a), ifa.cpu_rdata, (a == 9) ? 8'h77 : 8'hFF);
    end
    ifa.cpu_en = 0;

    // DUT B: full fill 0x11, then 0x33 fill aborted by reset at address 8
    ifb.fill_start = 1; ifb.fill_value = 8'h11;
    tick();
    ifb.fill_start = 0;
    for (int k = 0; k < 17; k++) tick();
    chk("b_fill1_idle", ifb.fill_busy, 1'b0);
    ifb.cpu_en = 1; ifb.cpu_we = 0; ifb.cpu_addr = 4'h0;
    ifb.vid_en = 1; ifb.vid_addr = 4'h0;
    tick();
    ifb.cpu_en = 0;
    chk("b_pre_cpu_rdata", ifb.cpu_rdata, 8'h11);
    ifb.fill_start = 1; ifb.fill_value = 8'h33;
    tick();
    ifb.fill_start = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("b_pre_vid_valid", ifb.vid_valid, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("b_abort_busy", ifb.fill_busy, 1'b0);
    chk("b_abort_done", ifb.fill_done, 1'b0);
    chk("b_abort_cpu_rdata", ifb.cpu_rdata, 8'h00);
    chk("b_abort_vid_rdata", ifb.vid_rdata, 8'h00);
    chk("b_abort_vid_valid", ifb.vid_valid, 1'b0);
    ifb.vid_en = 0;
    tick();
    tick();
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("b_post_busy", ifb.fill_busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      ifb.cpu_en = 1; ifb.cpu_we = 0; ifb.cpu_addr = a[3:0];
      tick();
      chk($sformatf("b_word_%0d", a), ifb.cpu_rdata, (a < 8) ? 8'h33 : 8'h11);
    end
    ifb.cpu_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
